nn_sequencer: RTL and testbench

- Control unit that sequences the shared MAC datapath of neural_network through a two-layer fully-connected pass: input→hidden, then hidden→output.
- Generates weight, input and bias addresses plus datapath strobes, one neuron at a time.
- Exposes the top-level start/ready handshake.
- Sits between the neural_network top and its weight ROM, activation buffers and MAC/activation unit.

---
 rtl/nn_ctrl_pkg.sv | 25 ++
 rtl/nn_index_counter.sv | 38 +++
 rtl/nn_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_nn_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// nn_ctrl_pkg : shared state, layer and ROM-latency encodings for nn_sequencer
// Rev 1.0
//------------------------------------------------------------------------------
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_MAC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_BIAS  = 3'd4,
      ST_ACT   = 3'd5,
      ST_WRITE = 3'd6,
      ST_DONE  = 3'd7
   } nn_state_t;

   localparam logic c_layer_hid = 1'b0;
   localparam logic c_layer_out = 1'b1;

   localparam int   c_rom_lat   = 1;

endpackage
`default_nettype wire

// File: rtl/nn_index_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// nn_index_counter : loadable up-counter with clear, enable and terminal flag
// Rev 1.0
//------------------------------------------------------------------------------
module nn_index_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic [W-1:0] i_max,
   output logic [W-1:0] o_count,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en) begin
         r_count <= o_tc ? '0 : r_count + W'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == i_max);

endmodule
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// nn_sequencer : sequences the shared MAC datapath through a two-layer FC pass
// Rev 1.0
//------------------------------------------------------------------------------
module nn_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int N_HID  = 2,
   parameter int N_OUT  = 1,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ready,
   output logic              busy,
   output logic              layer,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] x_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic              acc_clr,
   output logic              mac_en,
   output logic              bias_en,
   output logic              act_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam logic [ADDR_W-1:0] c_n_in     = ADDR_W'(N_IN);
   localparam logic [ADDR_W-1:0] c_n_hid    = ADDR_W'(N_HID);
   localparam logic [ADDR_W-1:0] c_l1_base  = ADDR_W'(N_HID * N_IN);
   localparam logic [ADDR_W-1:0] c_src0_max = ADDR_W'(N_IN - 1);
   localparam logic [ADDR_W-1:0] c_src1_max = ADDR_W'(N_HID - 1);
   localparam logic [ADDR_W-1:0] c_dst0_max = ADDR_W'(N_HID - 1);
   localparam logic [ADDR_W-1:0] c_dst1_max = ADDR_W'(N_OUT - 1);

   if (N_IN < 1 || N_HID < 1 || N_OUT < 1 ||
       (N_HID * N_IN + N_OUT * N_HID) > (2 ** ADDR_W) ||
       (N_HID + N_OUT) > (2 ** ADDR_W)) begin : g_param_check
      $error("nn_sequencer: layer sizes do not fit in ADDR_W address bits");
   end

   nn_state_t              r_state;
   logic                   r_start_q;
   logic                   r_ready;
   logic                   r_busy;
   logic                   r_layer;
   logic                   r_acc_clr;
   logic                   r_bias_en;
   logic                   r_act_en;
   logic                   r_wr_en;
   logic [c_rom_lat-1:0]   r_mac_pipe;

   logic                   w_start_edge;
   logic [ADDR_W-1:0]      w_idx;
   logic [ADDR_W-1:0]      w_nrn;
   logic [ADDR_W-1:0]      w_src_max;
   logic [ADDR_W-1:0]      w_dst_max;
   logic                   w_idx_tc;
   logic                   w_nrn_tc;
   logic                   w_idx_clr;
   logic                   w_idx_en;
   logic                   w_nrn_clr;
   logic                   w_nrn_en;

   assign w_start_edge = start & ~r_start_q;
   assign w_src_max    = (r_layer == c_layer_out) ? c_src1_max : c_src0_max;
   assign w_dst_max    = (r_layer == c_layer_out) ? c_dst1_max : c_dst0_max;

   assign w_idx_clr = (r_state == ST_CLR);
   assign w_idx_en  = (r_state == ST_MAC) & ~w_idx_tc;
   // Neuron restarts at 0 both on run acceptance and on the hidden->output layer switch.
   assign w_nrn_clr = ((r_state == ST_IDLE) & w_start_edge) |
                      ((r_state == ST_WRITE) & w_nrn_tc & (r_layer == c_layer_hid));
   assign w_nrn_en  = (r_state == ST_WRITE) & ~w_nrn_tc;

   nn_index_counter #(.W(ADDR_W)) u_idx_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_idx_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_en       (w_idx_en),
      .i_max      (w_src_max),
      .o_count    (w_idx),
      .o_tc       (w_idx_tc)
   );

   nn_index_counter #(.W(ADDR_W)) u_nrn_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_nrn_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_en       (w_nrn_en),
      .i_max      (w_dst_max),
      .o_count    (w_nrn),
      .o_tc       (w_nrn_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_start_q  <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_layer    <= c_layer_hid;
         r_acc_clr  <= 1'b0;
         r_bias_en  <= 1'b0;
         r_act_en   <= 1'b0;
         r_wr_en    <= 1'b0;
         r_mac_pipe <= '0;
      end else begin
         r_start_q  <= start;
         r_acc_clr  <= 1'b0;
         r_bias_en  <= 1'b0;
         r_act_en   <= 1'b0;
         r_wr_en    <= 1'b0;
         // ROM read data arrives c_rom_lat cycles after the address is issued.
         r_mac_pipe[0] <= (r_state == ST_MAC);
         for (int i = 1; i < c_rom_lat; i++) begin
            r_mac_pipe[i] <= r_mac_pipe[i-1];
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_layer   <= c_layer_hid;
                  r_acc_clr <= 1'b1;
                  r_state   <= ST_CLR;
               end
            end
            ST_CLR:   r_state <= ST_MAC;
            ST_MAC: begin
               if (w_idx_tc) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_bias_en <= 1'b1;
               r_state   <= ST_BIAS;
            end
            ST_BIAS: begin
               r_act_en <= 1'b1;
               r_state  <= ST_ACT;
            end
            ST_ACT: begin
               r_wr_en <= 1'b1;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (!w_nrn_tc) begin
                  r_acc_clr <= 1'b1;
                  r_state   <= ST_CLR;
               end else if (r_layer == c_layer_hid) begin
                  r_layer   <= c_layer_out;
                  r_acc_clr <= 1'b1;
                  r_state   <= ST_CLR;
               end else begin
                  // Result flags move on the edge into DONE so ready lands exactly on the last pass edge.
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready   = r_ready;
   assign busy    = r_busy;
   assign layer   = r_layer;
   assign acc_clr = r_acc_clr;
   assign mac_en  = r_mac_pipe[c_rom_lat-1];
   assign bias_en = r_bias_en;
   assign act_en  = r_act_en;
   assign wr_en   = r_wr_en;

   assign w_addr  = (r_layer == c_layer_out) ? (c_l1_base + w_nrn * c_n_hid + w_idx)
                                             : (w_nrn * c_n_in + w_idx);
   assign x_addr  = w_idx;
   assign b_addr  = (r_layer == c_layer_out) ? (c_n_hid + w_nrn) : w_nrn;
   assign wr_addr = w_nrn;

endmodule
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_nn_sequencer : self-checking bench for nn_sequencer against a timeline model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_nn_sequencer;

   localparam int N_IN   = 3;
   localparam int N_HID  = 2;
   localparam int N_OUT  = 1;
   localparam int ADDR_W = 8;
   localparam int T      = N_HID * (N_IN + 5) + N_OUT * (N_HID + 5);

   typedef struct { int w; int x; int l; } mac_rec_t;
   typedef struct { int wr; int l; int b; } wr_rec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              ready, busy, layer;
   logic              acc_clr, mac_en, bias_en, act_en, wr_en;
   logic [ADDR_W-1:0] w_addr, x_addr, b_addr, wr_addr;

   int n_vec = 0;
   int n_err = 0;

   // timeline model state
   bit   m_active = 0;
   bit   m_done   = 0;
   bit   m_sq     = 0;
   bit   m_idle;
   bit   m_edge;
   int   m_t      = 0;
   logic m_busy   = 1'b0;
   logic m_ready  = 1'b0;

   bit                cap_en = 0;
   logic [ADDR_W-1:0] pw, px;
   logic              pl;
   mac_rec_t          cap_mac[$];
   wr_rec_t           cap_wr[$];
   mac_rec_t          mac_tbl[8];
   wr_rec_t           wr_tbl[3];

   int lat, rises;
   logic prev_r;

   always #5 clk = ~clk;

   nn_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .ready   (ready),
      .busy    (busy),
      .layer   (layer),
      .w_addr  (w_addr),
      .x_addr  (x_addr),
      .b_addr  (b_addr),
      .acc_clr (acc_clr),
      .mac_en  (mac_en),
      .bias_en (bias_en),
      .act_en  (act_en),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs t cycles after the accepting edge, walking the neuron schedule.
   function automatic void model_at(input int t, output logic [4:0] s, output int lay,
                                    output bit aok, output int w, output int x,
                                    output int b, output int wr);
      int base;
      s = '0; lay = 0; aok = 0; w = 0; x = 0; b = 0; wr = 0; base = 0;
      for (int g = 0; g < N_HID + N_OUT; g++) begin
         int l, nrn, n, p;
         l   = (g < N_HID) ? 0 : 1;
         nrn = (l == 0) ? g : g - N_HID;
         n   = (l == 0) ? N_IN : N_HID;
         if (t >= base && t < base + n + 5) begin
            p   = t - base;
            lay = l; b = g; wr = nrn;
            s   = {p == 0, (p >= 2 && p <= n + 1), p == n + 2, p == n + 3, p == n + 4};
            if (p >= 1 && p <= n) begin
               aok = 1;
               x   = p - 1;
               w   = (l == 0) ? nrn * N_IN + x : N_HID * N_IN + nrn * N_HID + x;
            end
         end
         base += n + 5;
      end
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_active = 0; m_done = 0; m_sq = 0; m_t = 0; m_busy = 1'b0; m_ready = 1'b0;
      end else begin
         m_idle = !m_active && !m_done;
         m_edge = start && !m_sq;
         m_sq   = start;
         m_done = 0;
         if (m_active) begin
            m_t++;
            if (m_t == T) begin
               m_active = 0; m_done = 1; m_busy = 1'b0; m_ready = 1'b1;
            end
         end else if (m_idle && m_edge) begin
            m_active = 1; m_t = 0; m_busy = 1'b1; m_ready = 1'b0;
         end
      end
   end

   task automatic check_cycle();
      logic [4:0] es;
      int lay, w, x, b, wr;
      bit aok;
      mac_rec_t mr;
      wr_rec_t  wq;
      es = '0; lay = 0; w = 0; x = 0; b = 0; wr = 0; aok = 0;
      if (m_active) model_at(m_t, es, lay, aok, w, x, b, wr);
      chk("acc_clr", acc_clr, es[4]);
      chk("mac_en",  mac_en,  es[3]);
      chk("bias_en", bias_en, es[2]);
      chk("act_en",  act_en,  es[1]);
      chk("wr_en",   wr_en,   es[0]);
      chk("busy",    busy,    m_busy);
      chk("ready",   ready,   m_ready);
      if (m_active) begin
         chk("layer",   layer,   lay);
         chk("b_addr",  b_addr,  b);
         chk("wr_addr", wr_addr, wr);
         if (aok) begin
            chk("w_addr", w_addr, w);
            chk("x_addr", x_addr, x);
         end
      end
      if (cap_en) begin
         if (mac_en) begin
            mr.w = int'(pw); mr.x = int'(px); mr.l = int'(pl);
            cap_mac.push_back(mr);
         end
         if (wr_en) begin
            wq.wr = int'(wr_addr); wq.l = int'(layer); wq.b = int'(b_addr);
            cap_wr.push_back(wq);
         end
      end
      pw = w_addr; px = x_addr; pl = layer;
   endtask

   initial forever begin
      @(negedge clk);
      check_cycle();
   end

   task automatic all_zero(input string tag);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_layer"}, layer, 0);
      chk({tag, "_strobes"}, {acc_clr, mac_en, bias_en, act_en, wr_en}, 0);
      chk({tag, "_w_addr"}, w_addr, 0);
      chk({tag, "_x_addr"}, x_addr, 0);
      chk({tag, "_b_addr"}, b_addr, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
   endtask

   // Entered at posedge+2 with start low; returns edges from acceptance to ready.
   task automatic run_and_time(input int repulse_at, output int lat_o);
      bit found;
      found = 0;
      lat_o = 99;
      start = 1'b1;
      @(posedge clk); #1;
      chk("accept_ready", ready, 0);
      chk("accept_busy", busy, 1);
      #1 start = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         @(posedge clk); #1;
         if (ready) begin
            found = 1;
            lat_o = i;
         end
         #1 start = (i == repulse_at);
      end
      start = 1'b0;
   endtask

   initial begin
      mac_tbl[0] = '{0, 0, 0}; mac_tbl[1] = '{1, 1, 0}; mac_tbl[2] = '{2, 2, 0};
      mac_tbl[3] = '{3, 0, 0}; mac_tbl[4] = '{4, 1, 0}; mac_tbl[5] = '{5, 2, 0};
      mac_tbl[6] = '{6, 0, 1}; mac_tbl[7] = '{7, 1, 1};
      wr_tbl[0]  = '{0, 0, 0}; wr_tbl[1]  = '{1, 0, 1}; wr_tbl[2]  = '{0, 1, 2};

      repeat (3) @(posedge clk);
      #2 all_zero("reset");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // clean run with address/write trace capture
      cap_en = 1;
      run_and_time(0, lat);
      chk("latency", lat, T);
      cap_en = 0;
      chk("mac_count", cap_mac.size(), 8);
      for (int i = 0; i < 8 && i < cap_mac.size(); i++) begin
         chk($sformatf("trace_w[%0d]", i), cap_mac[i].w, mac_tbl[i].w);
         chk($sformatf("trace_x[%0d]", i), cap_mac[i].x, mac_tbl[i].x);
         chk($sformatf("trace_l[%0d]", i), cap_mac[i].l, mac_tbl[i].l);
      end
      chk("wr_pulses", cap_wr.size(), 3);
      for (int i = 0; i < 3 && i < cap_wr.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), cap_wr[i].wr, wr_tbl[i].wr);
         chk($sformatf("wr_layer[%0d]", i), cap_wr[i].l, wr_tbl[i].l);
         chk($sformatf("wr_b_addr[%0d]", i), cap_wr[i].b, wr_tbl[i].b);
      end
      repeat (3) @(posedge clk);
      #2;

      // start re-pulsed in the middle of a run
      run_and_time(10, lat);
      chk("latency_repulse", lat, T);
      repeat (3) @(posedge clk);
      #2;

      // start held high for 50 cycles gives one run only
      start  = 1'b1;
      prev_r = ready;
      rises  = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (ready && !prev_r) rises++;
         prev_r = ready;
         #1;
      end
      chk("hold_runs", rises, 1);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      run_and_time(0, lat);
      chk("latency_after_hold", lat, T);
      repeat (3) @(posedge clk);
      #2;

      // reset asserted mid-run
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (11) @(posedge clk);
      #2 rst = 1'b0;
      #1 all_zero("midrun_reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2;
      run_and_time(0, lat);
      chk("latency_after_reset", lat, T);
      repeat (3) @(posedge clk);
      #2;

      // random start activity, every cycle checked against the model
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #2;
         if ($urandom_range(0, 5) == 0) start = ~start;
      end
      start = 1'b0;
      repeat (30) @(posedge clk);
      #2;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before 1000000");
      $fatal(1);
   end

endmodule
`default_nettype wire
